// File: rtl/axi_sram_slave.sv
// AXI4 responder terminating one read or write burst at a time into a single-port SRAM.
// Optional macro AXI_SRAM_OOB_SLVERR_EN: per-beat range check with SLVERR on out-of-range beats.
module axi_sram_slave #(
   parameter int unsigned        DATA_W    = 512,
   parameter int unsigned        ID_W      = 4,
   parameter int unsigned        ADDR_W    = 64,
   parameter int unsigned        DEPTH     = 4096,
   parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  ar_valid_i,
   output logic                  ar_ready_o,
   input  logic [ID_W-1:0]       ar_id_i,
   input  logic [ADDR_W-1:0]     ar_addr_i,
   input  logic [7:0]            ar_len_i,
   input  logic [1:0]            ar_burst_i,
   output logic                  r_valid_o,
   input  logic                  r_ready_i,
   output logic [ID_W-1:0]       r_id_o,
   output logic [DATA_W-1:0]     r_data_o,
   output logic [1:0]            r_resp_o,
   output logic                  r_last_o,
   input  logic                  aw_valid_i,
   output logic                  aw_ready_o,
   input  logic [ID_W-1:0]       aw_id_i,
   input  logic [ADDR_W-1:0]     aw_addr_i,
   input  logic [7:0]            aw_len_i,
   input  logic [1:0]            aw_burst_i,
   input  logic                  w_valid_i,
   output logic                  w_ready_o,
   input  logic [DATA_W-1:0]     w_data_i,
   input  logic [DATA_W/8-1:0]   w_strb_i,
   input  logic                  w_last_i,
   output logic                  b_valid_o,
   input  logic                  b_ready_i,
   output logic [ID_W-1:0]       b_id_o,
   output logic [1:0]            b_resp_o
);
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned SHIFT  = $clog2(STRB_W);
   localparam int unsigned IDX_W  = $clog2(DEPTH);
`ifdef AXI_SRAM_OOB_SLVERR_EN
   localparam int unsigned WORD_W = ADDR_W - SHIFT;
`else
   localparam int unsigned WORD_W = IDX_W;
`endif
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {IDLE, RD, WR_DATA, WR_RESP} state_e;

   state_e              state_q, state_d;
   logic                prio_wr_q, prio_wr_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic                fixed_q, fixed_d;
   logic [7:0]          len_q, len_d;
   logic [8:0]          cnt_q, cnt_d;
   logic [ID_W-1:0]     r_id_q, r_id_d, b_id_q, b_id_d;
   logic                r_valid_q, r_valid_d, r_last_q, r_last_d;
   logic [DATA_W-1:0]   r_data_q, r_data_d;
   logic [1:0]          r_resp_q, r_resp_d, b_resp_q, b_resp_d;
   logic                b_valid_q, b_valid_d, werr_q, werr_d;

   logic [DATA_W-1:0]   mem [DEPTH];
   logic [IDX_W-1:0]    idx;
   logic                oob, in_burst, w_hs, rd_issue, mem_we;

   assign idx      = word_q[IDX_W-1:0];
`ifdef AXI_SRAM_OOB_SLVERR_EN
   assign oob      = (word_q >= WORD_W'(DEPTH));
`else
   assign oob      = 1'b0;
`endif
   assign in_burst = (cnt_q <= {1'b0, len_q});

   // Address channels only open in IDLE; contested cycles resolved by the priority flag
   assign ar_ready_o = !rst_i && (state_q == IDLE) && ar_valid_i && (!aw_valid_i || !prio_wr_q);
   assign aw_ready_o = !rst_i && (state_q == IDLE) && aw_valid_i && (!ar_valid_i || prio_wr_q);
   assign w_ready_o  = !rst_i && (state_q == WR_DATA);

   assign w_hs     = w_ready_o && w_valid_i;
   assign rd_issue = (state_q == RD) && in_burst && (!r_valid_q || r_ready_i);
   assign mem_we   = w_hs && in_burst && !oob;

   assign r_valid_o = r_valid_q;
   assign r_id_o    = r_id_q;
   assign r_data_o  = r_data_q;
   assign r_resp_o  = r_resp_q;
   assign r_last_o  = r_last_q;
   assign b_valid_o = b_valid_q;
   assign b_id_o    = b_id_q;
   assign b_resp_o  = b_resp_q;

   always_comb begin
      state_d   = state_q;
      prio_wr_d = prio_wr_q;
      word_d    = word_q;
      fixed_d   = fixed_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      r_id_d    = r_id_q;
      b_id_d    = b_id_q;
      r_valid_d = r_valid_q;
      r_last_d  = r_last_q;
      r_data_d  = r_data_q;
      r_resp_d  = r_resp_q;
      b_valid_d = b_valid_q;
      b_resp_d  = b_resp_q;
      werr_d    = werr_q;
      unique case (state_q)
         IDLE: begin
            if (ar_ready_o) begin
               state_d   = RD;
               prio_wr_d = 1'b1;
               word_d    = WORD_W'((ar_addr_i - BASE_ADDR) >> SHIFT);
               fixed_d   = (ar_burst_i == 2'b00);
               len_d     = ar_len_i;
               cnt_d     = '0;
               r_id_d    = ar_id_i;
            end else if (aw_ready_o) begin
               state_d   = WR_DATA;
               prio_wr_d = 1'b0;
               word_d    = WORD_W'((aw_addr_i - BASE_ADDR) >> SHIFT);
               fixed_d   = (aw_burst_i == 2'b00);
               len_d     = aw_len_i;
               cnt_d     = '0;
               b_id_d    = aw_id_i;
               werr_d    = 1'b0;
            end
         end
         RD: begin
            if (r_valid_q && r_ready_i) begin
               r_valid_d = 1'b0;
               if (r_last_q) state_d = IDLE;
            end
            // Issue the next SRAM read whenever the output register is free or draining
            if (rd_issue) begin
               r_valid_d = 1'b1;
               r_last_d  = (cnt_q == {1'b0, len_q});
               r_data_d  = oob ? '0 : mem[idx];
               r_resp_d  = oob ? RESP_SLVERR : RESP_OKAY;
               cnt_d     = cnt_q + 9'd1;
               if (!fixed_q) word_d = word_q + WORD_W'(1);
            end
         end
         WR_DATA: begin
            if (w_hs) begin
               if (in_burst && !fixed_q) word_d = word_q + WORD_W'(1);
               if (cnt_q != '1) cnt_d = cnt_q + 9'd1;
               if (in_burst && oob) werr_d = 1'b1;
               if (w_last_i) begin
                  state_d   = WR_RESP;
                  b_valid_d = 1'b1;
                  b_resp_d  = (werr_q || (in_burst && oob) || (cnt_q != {1'b0, len_q}))
                              ? RESP_SLVERR : RESP_OKAY;
               end
            end
         end
         WR_RESP: begin
            if (b_ready_i) begin
               b_valid_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         prio_wr_q <= 1'b0;
         word_q    <= '0;
         fixed_q   <= 1'b0;
         len_q     <= '0;
         cnt_q     <= '0;
         r_id_q    <= '0;
         b_id_q    <= '0;
         r_valid_q <= 1'b0;
         r_last_q  <= 1'b0;
         r_data_q  <= '0;
         r_resp_q  <= RESP_OKAY;
         b_valid_q <= 1'b0;
         b_resp_q  <= RESP_OKAY;
         werr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         prio_wr_q <= prio_wr_d;
         word_q    <= word_d;
         fixed_q   <= fixed_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         r_id_q    <= r_id_d;
         b_id_q    <= b_id_d;
         r_valid_q <= r_valid_d;
         r_last_q  <= r_last_d;
         r_data_q  <= r_data_d;
         r_resp_q  <= r_resp_d;
         b_valid_q <= b_valid_d;
         b_resp_q  <= b_resp_d;
         werr_q    <= werr_d;
      end
   end

   // Byte-lane write port of the SRAM array
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (w_strb_i[b]) mem[idx][8*b +: 8] <= w_data_i[8*b +: 8];
         end
      end
   end
endmodule
